// File: rtl/seq_pattern_detector_pkg.sv
// rtl/seq_pattern_detector_pkg.sv - shared types and helpers for the pattern detector
package seq_pattern_detector_pkg;

   typedef enum logic [1:0] {
      UNCFG  = 2'd0,
      FILL   = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   localparam int MASK_W = 32;

   // Low len bits set; callers size-cast the result down to their pattern width.
   function automatic logic [MASK_W-1:0] len_mask(input int len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // A clear coinciding with an increment still records that event.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = inc ? W'(1) : '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-programmable serial bit-pattern detector
import seq_pattern_detector_pkg::*;

module seq_pattern_detector #(
   parameter  int PAT_W = 8,
   parameter  int CNT_W = 16,
   localparam int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             din_valid,
   input  logic             din,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             armed,
   output logic             cfg_err
);

   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             overlap_q, overlap_d;
   logic             match_q, match_d;
   logic             armed_q, armed_d;
   logic             cfg_err_q, cfg_err_d;

   logic [PAT_W-1:0] hist_n;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill_inc;
   logic             cfg_legal;
   logic             cfg_accept;
   logic             hit;

   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      pattern_d  = pattern_q;
      len_d      = len_q;
      fill_d     = fill_q;
      overlap_d  = overlap_q;
      armed_d    = armed_q;
      match_d    = 1'b0;
      cfg_err_d  = 1'b0;
      hit        = 1'b0;
      hist_n     = {hist_q[PAT_W-2:0], din};
      mask       = PAT_W'(len_mask(int'(len_q)));
      fill_inc   = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
      cfg_legal  = (cfg_len != '0) && (cfg_len <= PAT_W_L);
      cfg_accept = cfg_load && cfg_legal;

      // A config load wins over a data bit arriving in the same cycle.
      if (cfg_load) begin
         if (cfg_legal) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = FILL;
            armed_d   = 1'b1;
         end else begin
            pattern_d = '0;
            len_d     = '0;
            overlap_d = 1'b0;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = UNCFG;
            armed_d   = 1'b0;
            cfg_err_d = 1'b1;
         end
      end else if (din_valid && (state_q != UNCFG)) begin
         hist_d = hist_n;
         hit    = (fill_inc == len_q) && (((hist_n ^ pattern_q) & mask) == '0);
         if (hit) begin
            match_d = 1'b1;
            fill_d  = overlap_q ? len_q : '0;
            state_d = overlap_q ? ACTIVE : FILL;
         end else begin
            fill_d  = fill_inc;
            state_d = (fill_inc == len_q) ? ACTIVE : FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= UNCFG;
         hist_q    <= '0;
         pattern_q <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         overlap_q <= 1'b0;
         match_q   <= 1'b0;
         armed_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         fill_q    <= fill_d;
         overlap_q <= overlap_d;
         match_q   <= match_d;
         armed_q   <= armed_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr | cfg_accept),
      .inc   (hit),
      .count (match_count)
   );

   assign match   = match_q;
   assign armed   = armed_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - randomized and directed bench with a queue-based reference model
module tb_seq_pattern_detector;

   logic        clk = 1'b0;
   logic        rst, cfg_load, cfg_overlap, din_valid, din, cnt_clr;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic        match, armed, cfg_err;
   logic [15:0] match_count;
   logic        match_c2, armed_c2, cfg_err_c2;
   logic [1:0]  match_count_c2;

   int n_checks = 0;
   int n_pass   = 0;
   int match_seen;

   bit   mq[$];
   bit   m_armed, m_ovl;
   logic [7:0] m_pat;
   int   m_len, m_cnt16, m_cnt2;
   bit   exp_match, exp_err;

   always #5 clk = ~clk;

   seq_pattern_detector dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
      .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .armed(armed),
      .cfg_err(cfg_err)
   );

   seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
      .cnt_clr(cnt_clr), .match(match_c2), .match_count(match_count_c2), .armed(armed_c2),
      .cfg_err(cfg_err_c2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: a match is the last len accepted bits (since config or last restart) equalling the pattern.
   task automatic model_step();
      bit hit;
      hit       = 0;
      exp_match = 0;
      exp_err   = 0;
      if (rst) begin
         mq.delete();
         m_armed = 0; m_ovl = 0; m_pat = 0; m_len = 0; m_cnt16 = 0; m_cnt2 = 0;
         return;
      end
      if (cfg_load) begin
         if (cfg_len >= 1 && cfg_len <= 8) begin
            m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap; m_armed = 1;
            mq.delete();
            m_cnt16 = 0; m_cnt2 = 0;
         end else begin
            exp_err = 1; m_armed = 0; m_pat = 0; m_len = 0; m_ovl = 0;
            mq.delete();
         end
      end else if (din_valid && m_armed) begin
         mq.push_back(din);
         if (mq.size() > 8) void'(mq.pop_front());
         if (mq.size() >= m_len) begin
            hit = 1;
            for (int k = 0; k < m_len; k++)
               if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
         end
         if (hit) begin
            exp_match = 1;
            if (!m_ovl) mq.delete();
         end
      end
      if (cnt_clr) begin
         m_cnt16 = hit ? 1 : 0;
         m_cnt2  = hit ? 1 : 0;
      end else if (hit) begin
         m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
         m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      if (match) match_seen++;
      check("match", match, exp_match);
      check("match_c2", match_c2, exp_match);
      check("count", match_count, m_cnt16);
      check("count_c2", match_count_c2, m_cnt2);
      check("armed", armed, m_armed);
      check("armed_c2", armed_c2, m_armed);
      check("cfg_err", cfg_err, exp_err);
      check("cfg_err_c2", cfg_err_c2, exp_err);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      cfg_load = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      cycle();
      cfg_load = 0;
   endtask

   task automatic send_bit(input logic b);
      din_valid = 1; din = b;
      cycle();
      din_valid = 0;
   endtask

   task automatic send_stream(input logic [15:0] s, input int n, input int max_gap);
      for (int i = n - 1; i >= 0; i--) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int j = 0; j < g; j++) cycle();
         send_bit(s[i]);
      end
   endtask

   initial begin
      rst = 1; cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
      din_valid = 0; din = 0; cnt_clr = 0;
      cycle();
      cycle();
      check("rst_match", match, 0);
      check("rst_count", match_count, 0);
      check("rst_armed", armed, 0);
      rst = 0;
      send_bit(1);

      // Legacy 11010 detector, non-overlapping
      load(8'b11010, 5, 0);
      match_seen = 0;
      send_stream(16'b1101011010, 10, 0);
      check("t1_pulses", match_seen, 2);
      check("t1_count", match_count, 2);

      load(8'b101, 3, 1);
      match_seen = 0;
      send_stream(16'b10101, 5, 0);
      check("t2_ovl1", match_seen, 2);
      load(8'b101, 3, 0);
      match_seen = 0;
      send_stream(16'b10101, 5, 0);
      check("t2_ovl0", match_seen, 1);

      // Gaps in din_valid must not change the result
      load(8'b1101, 4, 1);
      match_seen = 0;
      send_stream(16'b1101101101, 10, 0);
      check("t3_nogap", match_seen, 3);
      load(8'b1101, 4, 1);
      match_seen = 0;
      send_stream(16'b1101101101, 10, 3);
      check("t3_gap", match_seen, 3);
      check("t3_count", match_count, 3);

      // Length 1 and counter saturation on the narrow instance
      load(8'b1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         send_bit(1);
         check("t4_sat", match_count_c2, (i + 1 > 3) ? 3 : i + 1);
      end
      cnt_clr = 1;
      send_bit(1);
      cnt_clr = 0;
      check("t4_clr_hit", match_count_c2, 1);

      // Illegal lengths
      load(8'h5, 0, 1);
      check("t5_err0", cfg_err, 1);
      check("t5_armed0", armed, 0);
      send_stream(16'b10101, 5, 0);
      load(8'h5, 9, 1);
      check("t5_err9", cfg_err, 1);
      match_seen = 0;
      send_stream(16'b10101, 5, 0);
      check("t5_nomatch", match_seen, 0);
      load(8'h5, 3, 1);
      check("t5_armed", armed, 1);

      // Reset mid-pattern and on the match cycle
      load(8'b11010, 5, 0);
      send_stream(16'b110, 3, 0);
      rst = 1; cycle(); rst = 0;
      check("t6_armed", armed, 0);
      check("t6_count", match_count, 0);
      send_stream(16'b11010, 5, 0);
      load(8'b11010, 5, 0);
      send_stream(16'b11010, 5, 0);
      check("t6_match_pre", match, 1);
      rst = 1; cycle(); rst = 0;
      check("t6_match_rst", match, 0);
      check("t6_count_rst", match_count, 0);

      // Randomized traffic
      load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
      for (int it = 0; it < 3000; it++) begin
         int r;
         r = $urandom_range(0, 199);
         cfg_load    = (r < 5);
         cfg_pattern = 8'($urandom);
         cfg_len     = (r == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         cfg_overlap = 1'($urandom);
         rst         = (r == 5);
         cnt_clr     = (r == 6 || r == 7);
         din_valid   = ($urandom_range(0, 3) != 0);
         din         = 1'($urandom);
         cycle();
         if (rst || !m_armed) begin
            rst = 0;
            load(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom));
         end
      end
      rst = 0; cfg_load = 0; cnt_clr = 0; din_valid = 0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
